// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared state encoding and default sizing for the EQ sequencer
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eq_seq_state_t;

  localparam int EQ_TAPS = 1021;
  localparam int EQ_PIPE = 3;

endpackage

// File: rtl/eq_tap_cnt.sv
// rtl/eq_tap_cnt.sv - loadable up-counter with terminal-count flag for RUN/DRAIN timing
module eq_tap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/eq_seq_ctrl.sv
// rtl/eq_seq_ctrl.sv - EQ FIR pass sequencer; EQ_OVR_CNT_EN adds the dropped-sample counter ovr_cnt
module eq_seq_ctrl
  import eq_pkg::*;
#(
  parameter int TAPS = EQ_TAPS,
  parameter int PIPE = EQ_PIPE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic                    clr_ovr,
  output logic                    wrt_smpl_high,
  output logic                    wrt_smpl_low,
  output logic                    seq_high,
  output logic                    seq_low,
  output logic [$clog2(TAPS)-1:0] tap_addr,
  output logic                    out_vld,
  output logic                    busy,
  output logic                    overrun
`ifdef EQ_OVR_CNT_EN
  ,
  output logic [7:0]              ovr_cnt
`endif
);

  localparam int TAW  = $clog2(TAPS);
  localparam int CMAX = (TAPS > PIPE) ? TAPS : PIPE;
  localparam int CW   = $clog2(CMAX);

  eq_seq_state_t state_q, state_d;
  logic          phase_q, low_pass_q;
  logic          ovr_q, ovr_d;
  logic          accept, drop;
  logic          cnt_load, cnt_en, cnt_tc;
  logic [CW-1:0] cnt, term;

  // One counter serves both timed states; its terminal value follows the state.
  assign term = (state_q == RUN) ? CW'(TAPS - 1) : CW'(PIPE - 1);

  eq_tap_cnt #(.W(CW)) u_tap_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .term_i     (term),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    drop     = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (vld) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        drop = vld;
        if (cnt_tc) begin
          cnt_load = 1'b1;
          state_d  = DRAIN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DRAIN: begin
        drop = vld;
        if (cnt_tc) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (vld) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new drop wins over a same-cycle clear so no overrun is ever lost.
  always_comb begin
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      low_pass_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
      if (accept) begin
        phase_q    <= ~phase_q;
        low_pass_q <= ~phase_q;
      end
    end
  end

  always_comb begin
    wrt_smpl_high = 1'b0;
    wrt_smpl_low  = 1'b0;
    seq_high      = 1'b0;
    seq_low       = 1'b0;
    tap_addr      = '0;
    out_vld       = 1'b0;
    busy          = 1'b0;
    overrun       = 1'b0;
    if (!rst) begin
      wrt_smpl_high = accept;
      wrt_smpl_low  = accept & ~phase_q;
      seq_high      = (state_q == RUN);
      seq_low       = (state_q == RUN) & low_pass_q;
      tap_addr      = (state_q == RUN) ? cnt[TAW-1:0] : '0;
      out_vld       = (state_q == DONE);
      busy          = (state_q != IDLE);
      overrun       = ovr_q;
    end
  end

`ifdef EQ_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (clr_ovr) begin
      ovr_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (ovr_cnt_q != 8'hff)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign ovr_cnt = rst ? 8'd0 : ovr_cnt_q;
`endif

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// tb/tb_eq_seq_ctrl.sv - self-checking bench for eq_seq_ctrl against a pass-timing reference model
module tb_eq_seq_ctrl;

  localparam int TAPS = 8;
  localparam int PIPE = 3;
  localparam int TAW  = $clog2(TAPS);
  localparam int LAT  = TAPS + PIPE + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic clr_ovr = 1'b0;
  logic wrt_smpl_high, wrt_smpl_low, seq_high, seq_low, out_vld, busy, overrun;
  logic [TAW-1:0] tap_addr;
`ifdef EQ_OVR_CNT_EN
  logic [7:0] ovr_cnt;
  logic [7:0] exp_cnt;
  int         m_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;

  int cyc = -1;
  int m_start = 0;
  bit m_active = 0, m_phase = 0, m_low = 0, m_ovr = 0;
  bit e_accept = 0, e_drop = 0;
  logic [7+TAW-1:0] exp_vec;
  logic [7+TAW-1:0] obs_vec;

  always #5 clk = ~clk;

  eq_seq_ctrl #(.TAPS(TAPS), .PIPE(PIPE)) dut (
    .clk           (clk),
    .rst           (rst),
    .vld           (vld),
    .clr_ovr       (clr_ovr),
    .wrt_smpl_high (wrt_smpl_high),
    .wrt_smpl_low  (wrt_smpl_low),
    .seq_high      (seq_high),
    .seq_low       (seq_low),
    .tap_addr      (tap_addr),
    .out_vld       (out_vld),
    .busy          (busy),
    .overrun       (overrun)
`ifdef EQ_OVR_CNT_EN
    ,
    .ovr_cnt       (ovr_cnt)
`endif
  );

  assign obs_vec = {wrt_smpl_high, wrt_smpl_low, seq_high, seq_low, out_vld, busy, overrun, tap_addr};

  // Model: a pass is a time window after its accept cycle; everything derives from elapsed time.
  task automatic model_advance();
    if (cyc >= 0) begin
      if (rst) begin
        m_active = 0; m_phase = 0; m_low = 0; m_ovr = 0;
`ifdef EQ_OVR_CNT_EN
        m_cnt = 0;
`endif
      end else begin
        if (e_accept) begin
          m_start  = cyc;
          m_active = 1;
          m_low    = !m_phase;
          m_phase  = !m_phase;
        end
        if (e_drop) m_ovr = 1;
        else if (clr_ovr) m_ovr = 0;
`ifdef EQ_OVR_CNT_EN
        if (clr_ovr) m_cnt = e_drop ? 1 : 0;
        else if (e_drop && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic calc_exp();
    int t;
    bit run_m, done_m, busy_m;
    t      = cyc - m_start;
    run_m  = m_active && t >= 1 && t <= TAPS;
    done_m = m_active && t == LAT;
    busy_m = m_active && t >= 1 && t <= LAT;
    e_accept = !rst && vld && (!busy_m || done_m);
    e_drop   = !rst && vld && busy_m && !done_m;
    if (rst) exp_vec = '0;
    else exp_vec = {e_accept, e_accept && !m_phase, run_m, run_m && m_low, done_m, busy_m, m_ovr,
                    run_m ? TAW'(t - 1) : TAW'(0)};
`ifdef EQ_OVR_CNT_EN
    exp_cnt = rst ? 8'd0 : 8'(m_cnt);
`endif
  endtask

  task automatic apply(input bit v, input bit c, input bit r);
    model_advance();
    @(negedge clk);
    vld = v; clr_ovr = c; rst = r;
    #1;
    calc_exp();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      checks++;
      if (obs_vec !== '0) begin
        failures++; $display("FAIL reset_outputs cyc=%0d got=%b exp=0", cyc, obs_vec);
      end
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
    end
  endtask

  task automatic test_single();
    int t0, ov_at, hi_n, lo_n;
    ov_at = -1; hi_n = 0; lo_n = 0;
    apply(1'b1, 1'b0, 1'b0);
    t0 = cyc;
    checks++;
    if ({wrt_smpl_high, wrt_smpl_low} !== 2'b11) begin
      failures++; $display("FAIL single_strobes got=%b exp=11", {wrt_smpl_high, wrt_smpl_low});
    end
    for (int i = 1; i < 20; i++) begin
      apply(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
      end
      if (out_vld) ov_at = cyc - t0;
      if (seq_high) hi_n++;
      if (seq_low) lo_n++;
    end
    checks++;
    if (ov_at != 12 || hi_n != 8 || lo_n != 8) begin
      failures++; $display("FAIL single_timing out_vld_at=%0d seq_high=%0d seq_low=%0d exp=12/8/8", ov_at, hi_n, lo_n);
    end
  endtask

  task automatic test_second_pass();
    int hi_n, lo_n, wl_n;
    hi_n = 0; lo_n = 0; wl_n = 0;
    for (int i = 0; i < 20; i++) begin
      apply(i == 0, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL second_pass cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
      end
      if (seq_high) hi_n++;
      if (seq_low) lo_n++;
      if (wrt_smpl_low) wl_n++;
    end
    checks++;
    if (hi_n != 8 || lo_n != 0 || wl_n != 0) begin
      failures++; $display("FAIL second_pass_counts seq_high=%0d seq_low=%0d wrt_low=%0d exp=8/0/0", hi_n, lo_n, wl_n);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 20; i++) begin
      apply(i == 0 || i == 4, i == 14, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
      end
      if (i == 4 && (wrt_smpl_high !== 1'b0 || wrt_smpl_low !== 1'b0)) begin
        failures++; $display("FAIL overrun_strobe got=%b%b exp=00", wrt_smpl_high, wrt_smpl_low);
      end
      if (i == 5 && overrun !== 1'b1) begin
        failures++; $display("FAIL overrun_set got=%b exp=1", overrun);
      end
      if (i == 12 && out_vld !== 1'b1) begin
        failures++; $display("FAIL overrun_out_vld got=%b exp=1", out_vld);
      end
      if (i == 15 && overrun !== 1'b0) begin
        failures++; $display("FAIL overrun_clear got=%b exp=0", overrun);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 26; i++) begin
      apply(i == 0 || i == 12, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
      end
      if (i == 12 && {out_vld, wrt_smpl_high, wrt_smpl_low} !== 3'b111) begin
        failures++; $display("FAIL b2b_accept got=%b exp=111", {out_vld, wrt_smpl_high, wrt_smpl_low});
      end
      if (i == 13 && {seq_high, overrun} !== 2'b10) begin
        failures++; $display("FAIL b2b_run got=%b exp=10", {seq_high, overrun});
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 24; i++) begin
      apply(i == 0 || i == 8, 1'b0, i == 6);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
      end
      if (i == 5 && tap_addr !== TAW'(4)) begin
        failures++; $display("FAIL mid_reset_tap got=%0d exp=4", tap_addr);
      end
      if (i == 7 && obs_vec !== '0) begin
        failures++; $display("FAIL mid_reset_idle got=%b exp=0", obs_vec);
      end
      if (i == 8 && wrt_smpl_low !== 1'b1) begin
        failures++; $display("FAIL mid_reset_low_phase got=%b exp=1", wrt_smpl_low);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec, exp_vec);
      end
    end
  endtask

`ifdef EQ_OVR_CNT_EN
  task automatic test_ovr_cnt();
    apply(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 330; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      checks++;
      if (ovr_cnt !== exp_cnt) begin
        failures++; $display("FAIL ovr_cnt cyc=%0d got=%0d exp=%0d", cyc, ovr_cnt, exp_cnt);
      end
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (ovr_cnt !== 8'd255) begin
      failures++; $display("FAIL ovr_cnt_sat got=%0d exp=255", ovr_cnt);
    end
    apply(1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (ovr_cnt !== 8'd0) begin
      failures++; $display("FAIL ovr_cnt_clear got=%0d exp=0", ovr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_second_pass();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef EQ_OVR_CNT_EN
    test_ovr_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
